mem_dm: RTL and testbench

//  Data memory for the MEM stage of the 5-stage MIPS pipeline. Consumes MemOp, AO, WD and PC

---
 rtl/mem_dm.sv | 100 ++++++++++
 tb/tb_mem_dm.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_dm.sv
// MEM-stage data memory: word array with byte/half lane merge on store and sign/zero-extended loads.
// Optional store trace compiled in with `define DM_DISPLAY_EN.
module mem_dm #(
   parameter int unsigned DEPTH_W = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MemOp,
   input  logic [31:0] AO,
   input  logic [31:0] WD,
   input  logic [31:0] PC,
   output logic [31:0] RD
);

   localparam int unsigned DEPTH  = 1 << DEPTH_W;
   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DEPTH_W-1:0] idx;
   logic [1:0]         lane;
   logic [DATA_W-1:0]  old_word;
   logic [DATA_W-1:0]  merged_word;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic               is_store;

   assign idx      = AO[DEPTH_W+1:2];
   assign lane     = AO[1:0];
   assign old_word = mem[idx];
   assign is_store = (MemOp == OP_SB) || (MemOp == OP_SH) || (MemOp == OP_SW);

   // Upper address bits wrap by design; PC only feeds the optional trace.
   logic unused_bits;
   assign unused_bits = ^{AO[31:DEPTH_W+2], PC};

   // Lane merge: untouched lanes keep the current word contents.
   always_comb begin
      merged_word = old_word;
      case (MemOp)
         OP_SB: begin
            case (lane)
               2'd0:    merged_word[7:0]   = WD[7:0];
               2'd1:    merged_word[15:8]  = WD[7:0];
               2'd2:    merged_word[23:16] = WD[7:0];
               default: merged_word[31:24] = WD[7:0];
            endcase
         end
         OP_SH: begin
            if (lane[1]) merged_word[31:16] = WD[15:0];
            else         merged_word[15:0]  = WD[15:0];
         end
         OP_SW:   merged_word = WD;
         default: merged_word = old_word;
      endcase
   end

   // Load extraction from the pre-write array contents.
   always_comb begin
      byte_sel = 8'h00;
      half_sel = 16'h0000;
      RD       = old_word;
      case (lane)
         2'd0:    byte_sel = old_word[7:0];
         2'd1:    byte_sel = old_word[15:8];
         2'd2:    byte_sel = old_word[23:16];
         default: byte_sel = old_word[31:24];
      endcase
      half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
      case (MemOp)
         OP_LB:   RD = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  RD = {24'h000000, byte_sel};
         OP_LH:   RD = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  RD = {16'h0000, half_sel};
         default: RD = old_word;
      endcase
   end

   // Reset clears the whole array and overrides any coincident store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (is_store) begin
         mem[idx] <= merged_word;
`ifdef DM_DISPLAY_EN
         $display("%d@%h: *%h <= %h", $time, PC, {AO[31:2], 2'b00}, merged_word);
`endif
      end
   end

endmodule

// File: tb/tb_mem_dm.sv
// Scoreboard bench for mem_dm: directed loads/stores push expected RD, a negedge monitor checks.
module tb_mem_dm;

   logic        clk;
   logic        reset;
   logic [2:0]  MemOp;
   logic [31:0] AO;
   logic [31:0] WD;
   logic [31:0] PC;
   logic [31:0] RD;
   logic        chk;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   total;
   int   bad;

   mem_dm #(.DEPTH_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .MemOp (MemOp),
      .AO    (AO),
      .WD    (WD),
      .PC    (PC),
      .RD    (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after posedge; optionally queue the expected RD.
   task automatic step(input logic rst, input logic [2:0] op, input logic [31:0] ao,
                       input logic [31:0] wd, input logic do_chk, input logic [31:0] exp,
                       input string name);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      MemOp = op;
      AO    = ao;
      WD    = wd;
      PC    = 32'h0000_3000;
      chk   = do_chk;
      if (do_chk) begin
         e.exp  = exp;
         e.name = name;
         sbq.push_back(e);
      end
   endtask

   // Monitor: samples RD mid-cycle whenever a check is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL no_expected: RD=%h with empty scoreboard", RD);
            end else begin
               e = sbq.pop_front();
               if (RD !== e.exp) begin
                  bad++;
                  $display("FAIL %s: got %h expected %h", e.name, RD, e.exp);
               end
            end
         end
      end
   end

   initial begin
      int waited;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      MemOp = 3'd0;
      AO    = '0;
      WD    = '0;
      PC    = '0;
      chk   = 1'b0;

      step(1'b1, 3'd0, 32'h0,    32'h0,         1'b0, 32'h0,         "");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'h0000_0000, "reset_lw");
      // sw, same-cycle read still old data
      step(1'b0, 3'd7, 32'h10,   32'h1234_5678, 1'b1, 32'h0000_0000, "sw_rdw_old");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'h1234_5678, "lw_after_sw");
      // sb lane 3
      step(1'b0, 3'd5, 32'h13,   32'h0000_00AB, 1'b1, 32'h1234_5678, "sb_rdw_old");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'hAB34_5678, "lw_after_sb");
      step(1'b0, 3'd0, 32'h13,   32'h0,         1'b1, 32'hFFFF_FFAB, "lb_13");
      step(1'b0, 3'd1, 32'h13,   32'h0,         1'b1, 32'h0000_00AB, "lbu_13");
      step(1'b0, 3'd0, 32'h10,   32'h0,         1'b1, 32'h0000_0078, "lb_10");
      step(1'b0, 3'd1, 32'h11,   32'h0,         1'b1, 32'h0000_0056, "lbu_11");
      step(1'b0, 3'd2, 32'h12,   32'h0,         1'b1, 32'hFFFF_AB34, "lh_12");
      step(1'b0, 3'd3, 32'h10,   32'h0,         1'b1, 32'h0000_5678, "lhu_10");
      step(1'b0, 3'd3, 32'h11,   32'h0,         1'b1, 32'h0000_5678, "lhu_11_a0_ignored");
      // sh upper half on a zero word
      step(1'b0, 3'd6, 32'h22,   32'h0000_8001, 1'b1, 32'h0000_0000, "sh_rdw_old");
      step(1'b0, 3'd4, 32'h20,   32'h0,         1'b1, 32'h8001_0000, "lw_after_sh");
      step(1'b0, 3'd2, 32'h22,   32'h0,         1'b1, 32'hFFFF_8001, "lh_22");
      step(1'b0, 3'd3, 32'h22,   32'h0,         1'b1, 32'h0000_8001, "lhu_22");
      step(1'b0, 3'd2, 32'h20,   32'h0,         1'b1, 32'h0000_0000, "lh_20");
      step(1'b0, 3'd0, 32'h23,   32'h0,         1'b1, 32'hFFFF_FF80, "lb_23");
      step(1'b0, 3'd1, 32'h22,   32'h0,         1'b1, 32'h0000_0001, "lbu_22");
      step(1'b0, 3'd4, 32'h23,   32'h0,         1'b1, 32'h8001_0000, "lw_a10_ignored");
      // address wrap
      step(1'b0, 3'd7, 32'h4010, 32'hCAFE_F00D, 1'b1, 32'hAB34_5678, "sw_wrap_rdw");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'hCAFE_F00D, "lw_wrap");
      step(1'b0, 3'd0, 32'h10,   32'hFFFF_FFFF, 1'b1, 32'h0000_000D, "idle_lb");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'hCAFE_F00D, "idle_no_write");
      // reset beats coincident store
      step(1'b1, 3'd7, 32'h10,   32'h1111_1111, 1'b0, 32'h0,         "");
      step(1'b0, 3'd4, 32'h10,   32'h0,         1'b1, 32'h0000_0000, "reset_over_sw");
      step(1'b0, 3'd4, 32'h20,   32'h0,         1'b1, 32'h0000_0000, "reset_clears_20");
      step(1'b0, 3'd0, 32'h0,    32'h0,         1'b0, 32'h0,         "");

      waited = 0;
      while (sbq.size() != 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, required 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
